bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared 8-bit tristate data bus.
- Each bus driver (counter, registers, memory) raises a request line.
- The arbiter returns a registered one-hot output-enable that feeds the drivers' oe inputs, so at most one driver is ever enabled.
- It enforces a per-grant burst limit and inserts an all-off turnaround gap between owners so two drivers never fight on the bus.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 8: maximum consecutive grant cycles while another requester is waiting, 1..255.
- TURNAROUND, 1: all-off cycles inserted between two grants, 1..4.

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per driver; level-sensitive, held high while the driver wants the bus.
- oe  output  N_REQ  one-hot (or zero) output-enable to the drivers; registered.
- grant_id  output  3  index of the current owner; valid only while bus_busy=1.
- bus_busy  output  1  high when some oe bit is set.
- burst_cnt  output  8  grant cycles consumed by the current owner, for debug and verification.

Behaviour:
- States: IDLE, GRANT, TURN.
- Reset, applied on any clk edge with reset=1, from any state including mid-grant:
  - state=IDLE, oe=0, bus_busy=0, grant_id=0, burst_cnt=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority after reset.
- Arbitration function: first set bit of req, searching last+1, last+2, ... modulo N_REQ.
- IDLE:
  - oe=0.
  - If req!=0 at an edge: state becomes GRANT, oe gets the one-hot winner, grant_id=winner, last=winner, burst_cnt=1.
  - Latency: oe rises one cycle after req is first seen high.
- GRANT:
  - oe holds one bit for owner g.
  - Each edge, exactly one of the following applies, checked in this order:
    1. req[g]=0: release. State=TURN, oe=0, turnaround counter=TURNAROUND-1.
    2. burst_cnt==MAX_BURST and some other req bit is set: forced release, same as case 1.
    3. burst_cnt==MAX_BURST and no other req is set: keep the grant, burst_cnt=1. The owner keeps the bus for as long as it is alone.
    4. Otherwise: burst_cnt+1.
  - Max bus time for one grant while contended: exactly MAX_BURST cycles.
- TURN:
  - oe=0, bus_busy=0, burst_cnt=0.
  - Counter decrements each edge.
  - At the edge where the counter is 0: if req!=0, arbitrate as from IDLE (grant on that same edge); else go to IDLE.
  - Requests that rise or fall during TURN affect only that final arbitration.
  - The previous owner is eligible, but at lowest priority because last=g.
- Invariants, checked on every cycle:
  - popcount(oe)<=1.
  - Between a cycle with oe[a]=1 and a later cycle with oe[b]=1, a!=b, there are at least TURNAROUND cycles with oe=0.
  - bus_busy == |oe.
  - oe only changes on clk edges (registered, no combinational path from req).
- Starvation bound: a continuously requesting driver is granted within (N_REQ-1)*(MAX_BURST+TURNAROUND)+TURNAROUND+1 cycles.
- Width rules:
  - grant_id is zero-extended to 3 bits.
  - burst_cnt never exceeds MAX_BURST and does not wrap.

Test Plan:
- Reset/single requester: reset 2 cycles, then req=0001 held 20 cycles → oe=0001 from the cycle after req rises. burst_cnt runs 1..8, returns to 1, and repeats. No gap, bus_busy=1 throughout.
- Voluntary release: req=0100 for 3 cycles, then 0 → oe=0100 for 3 cycles, then oe=0 for 1 TURN cycle, then IDLE with oe=0 and grant_id ignored.
- Contention round-robin: req=1111 held → grant order 0,1,2,3,0 with default parameters. Each owner holds for exactly 8 cycles, followed by 1 zero cycle. popcount(oe)<=1 on every cycle.
- Forced release by a late requester: req=0001 held, req[2] rises while burst_cnt=5 → oe[0] drops after burst_cnt=8. Then 1 TURN cycle, then oe=0100.
- Reset mid-grant and mid-TURN: assert reset while oe=0010 and again during TURN → the next cycle oe=0, state IDLE. With req=0110, the first grant after reset goes to requester 1.
- TURNAROUND=3, N_REQ=2 build: req=11 → gap of exactly 3 zero-oe cycles between owners. Grants alternate 0,1,0 for 3 rounds.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
//
// Round-robin owner selection for the shared 8-bit tristate data bus. Each
// bus driver raises a level-sensitive request. The arbiter answers with a
// registered one-hot output-enable, so at most one driver ever drives the bus.
// While another driver is waiting, an owner keeps the bus for at most
// MAX_BURST cycles. An all-off gap of TURNAROUND cycles separates two owners.
//
// Ports
//   clk        rising-edge system clock
//   reset      synchronous, active-high reset
//   req        per-driver request, held high while the driver wants the bus
//   oe         registered one-hot (or zero) output-enable to the drivers
//   grant_id   index of the current owner, zero-extended; valid while bus_busy
//   bus_busy   high whenever some oe bit is set
//   burst_cnt  grant cycles used by the current owner (0 when nobody owns)
module bus_arbiter #(
  parameter int N_REQ      = 4,   // 2..8
  parameter int MAX_BURST  = 8,   // 1..255
  parameter int TURNAROUND = 1    // 1..4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] oe,
  output logic [2:0]       grant_id,
  output logic             bus_busy,
  output logic [7:0]       burst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [1:0] TURN_INIT   = 2'(TURNAROUND - 1);
  localparam logic [3:0] N_REQ_W     = 4'(N_REQ);
  localparam logic [2:0] LAST_RESET  = 3'(N_REQ - 1);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] oe_reg, oe_next;
  logic [2:0]       grant_id_reg, grant_id_next;
  logic [2:0]       last_reg, last_next;
  logic [7:0]       burst_cnt_reg, burst_cnt_next;
  logic [1:0]       turn_cnt_reg, turn_cnt_next;

  // ------------------------------------------------------------------
  // Round-robin winner search.
  // The request vector is rotated so that bit 0 of rot_req is requester
  // last+1. The lowest set bit of the rotated vector is the winner, and
  // adding its position back to last+1 (mod N_REQ) gives its real index.
  // ------------------------------------------------------------------
  logic [3:0]         rot_shamt;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_first;
  logic [2:0][N_REQ-1:0] pos_terms;
  logic [2:0]         win_pos;
  logic [3:0]         win_sum;
  logic [2:0]         win_idx;
  logic [N_REQ-1:0]   win_onehot;

  assign rot_shamt = {1'b0, last_reg} + 4'd1;
  assign req_dbl   = {req, req};
  assign rot_req   = N_REQ'(req_dbl >> rot_shamt);

  genvar gi, gb;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign rot_first[gi] = rot_req[gi];
      end else begin : g_upper
        // Set only when no lower-positioned rotated request is present.
        assign rot_first[gi] = rot_req[gi] & ~(|rot_req[gi-1:0]);
      end
      // Binary-encode the one-hot rot_first into win_pos, one bit at a time.
      for (gb = 0; gb < 3; gb++) begin : g_enc
        assign pos_terms[gb][gi] = rot_first[gi] & (((gi >> gb) % 2) == 1);
      end
      assign win_onehot[gi] = (win_idx == 3'(gi));
    end
    for (gb = 0; gb < 3; gb++) begin : g_pos
      assign win_pos[gb] = |pos_terms[gb];
    end
  endgenerate

  // last+1+pos is at most 2*N_REQ-1, so a single conditional subtract wraps it.
  assign win_sum = rot_shamt + {1'b0, win_pos};
  assign win_idx = (win_sum >= N_REQ_W) ? 3'(win_sum - N_REQ_W) : win_sum[2:0];

  // Owner still requesting / somebody else waiting. oe_reg is one-hot on the
  // owner while in GRANT, so it doubles as the owner mask.
  logic owner_req;
  logic other_req;
  assign owner_req = |(req & oe_reg);
  assign other_req = |(req & ~oe_reg);

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      oe_reg        <= '0;
      grant_id_reg  <= 3'd0;
      last_reg      <= LAST_RESET;
      burst_cnt_reg <= 8'd0;
      turn_cnt_reg  <= 2'd0;
    end else begin
      state_reg     <= state_next;
      oe_reg        <= oe_next;
      grant_id_reg  <= grant_id_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
      turn_cnt_reg  <= turn_cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  logic do_grant;

  always_comb begin
    state_next     = state_reg;
    oe_next        = oe_reg;
    grant_id_next  = grant_id_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    turn_cnt_next  = turn_cnt_reg;
    do_grant       = 1'b0;

    case (state_reg)
      IDLE: begin
        oe_next        = '0;
        burst_cnt_next = 8'd0;
        if (|req) begin
          do_grant = 1'b1;
        end
      end

      GRANT: begin
        if (!owner_req || ((burst_cnt_reg == BURST_LIMIT) && other_req)) begin
          // Voluntary or forced release: bus goes dark for TURNAROUND cycles.
          state_next     = TURN;
          oe_next        = '0;
          burst_cnt_next = 8'd0;
          turn_cnt_next  = TURN_INIT;
        end else if (burst_cnt_reg == BURST_LIMIT) begin
          // Uncontended owner keeps the bus; the burst window restarts.
          burst_cnt_next = 8'd1;
        end else begin
          burst_cnt_next = burst_cnt_reg + 8'd1;
        end
      end

      TURN: begin
        oe_next        = '0;
        burst_cnt_next = 8'd0;
        if (turn_cnt_reg == 2'd0) begin
          // The previous owner competes too, but last points at it, so it
          // comes last in the search order.
          if (|req) begin
            do_grant = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          turn_cnt_next = turn_cnt_reg - 2'd1;
        end
      end

      default: begin
        state_next     = IDLE;
        oe_next        = '0;
        burst_cnt_next = 8'd0;
      end
    endcase

    if (do_grant) begin
      state_next     = GRANT;
      oe_next        = win_onehot;
      grant_id_next  = win_idx;
      last_next      = win_idx;
      burst_cnt_next = 8'd1;
    end
  end

  assign oe        = oe_reg;
  assign grant_id  = grant_id_reg;
  assign bus_busy  = |oe_reg;
  assign burst_cnt = burst_cnt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter. It runs two instances side by side:
// dut_a with the default parameters (4 requesters, burst 8, gap 1) and
// dut_b with 2 requesters and a 3-cycle gap. A behavioural model tracks, for
// each instance, the bus owner, how long the owner has held the bus, how many
// dark cycles remain before the next grant, and the round-robin pointer.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_a = 4'd0;
  logic [1:0] req_b = 2'd0;

  logic [3:0] oe_a;
  logic [2:0] grant_id_a;
  logic       bus_busy_a;
  logic [7:0] burst_cnt_a;
  logic [1:0] oe_b;
  logic [2:0] grant_id_b;
  logic       bus_busy_b;
  logic [7:0] burst_cnt_b;

  bus_arbiter dut_a (
    .clk(clk), .reset(reset), .req(req_a), .oe(oe_a),
    .grant_id(grant_id_a), .bus_busy(bus_busy_a), .burst_cnt(burst_cnt_a)
  );

  bus_arbiter #(.N_REQ(2), .MAX_BURST(8), .TURNAROUND(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .oe(oe_b),
    .grant_id(grant_id_b), .bus_busy(bus_busy_b), .burst_cnt(burst_cnt_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // ---------------- behavioural model ----------------
  int p_n[2]   = '{4, 2};
  int p_max[2] = '{8, 8};
  int p_ta[2]  = '{1, 3};
  int m_owner[2];   // -1 when nobody owns the bus
  int m_held[2];    // cycles the owner has held the bus in this window
  int m_gap[2];     // dark cycles still required before a new grant
  int m_last[2];    // most recent owner

  task automatic model_reset(input int u);
    m_owner[u] = -1;
    m_held[u]  = 0;
    m_gap[u]   = 0;
    m_last[u]  = p_n[u] - 1;
  endtask

  task automatic model_step(input int u, input logic [7:0] r);
    int others;
    int idx;
    bit found;
    if (m_owner[u] >= 0) begin
      others = int'(r) & ~(1 << m_owner[u]) & ((1 << p_n[u]) - 1);
      if (!r[m_owner[u]] || (m_held[u] == p_max[u] && others != 0)) begin
        m_owner[u] = -1;
        m_held[u]  = 0;
        m_gap[u]   = p_ta[u];
      end else if (m_held[u] == p_max[u]) begin
        m_held[u] = 1;
      end else begin
        m_held[u] = m_held[u] + 1;
      end
    end else if (m_gap[u] > 1) begin
      m_gap[u] = m_gap[u] - 1;
    end else begin
      m_gap[u] = 0;
      found = 1'b0;
      for (int k = 1; k <= p_n[u]; k++) begin
        idx = (m_last[u] + k) % p_n[u];
        if (!found && r[idx]) begin
          found      = 1'b1;
          m_owner[u] = idx;
          m_last[u]  = idx;
          m_held[u]  = 1;
        end
      end
    end
  endtask

  // Expected {oe(4), bus_busy, burst_cnt(8), grant_id-or-0(3)}.
  function automatic logic [15:0] exp_vec(input int u);
    logic [3:0] e_oe;
    logic       e_busy;
    logic [2:0] e_gid;
    e_busy = (m_owner[u] >= 0);
    e_oe   = e_busy ? 4'(1 << m_owner[u]) : 4'd0;
    e_gid  = e_busy ? 3'(m_owner[u]) : 3'd0;
    return {e_oe, e_busy, 8'(m_held[u]), e_gid};
  endfunction

  function automatic logic [15:0] got_a();
    return {oe_a, bus_busy_a, burst_cnt_a, bus_busy_a ? grant_id_a : 3'd0};
  endfunction

  function automatic logic [15:0] got_b();
    return {2'b00, oe_b, bus_busy_b, burst_cnt_b, bus_busy_b ? grant_id_b : 3'd0};
  endfunction

  // One clock: the model sees the same req/reset values the DUTs sample.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, {4'b0000, req_a});
      model_step(1, {6'b000000, req_b});
    end
    #1;
  endtask

  // ---------------- per-cycle invariants ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ($countones(oe_a) > 1 || bus_busy_a !== (|oe_a))
        $display("FAIL inv_a t=%0t actual oe=%b busy=%b required onehot0 oe and busy=|oe", $time, oe_a, bus_busy_a);
      else
        n_pass++;
      n_checks++;
      if ($countones(oe_b) > 1 || bus_busy_b !== (|oe_b))
        $display("FAIL inv_b t=%0t actual oe=%b busy=%b required onehot0 oe and busy=|oe", $time, oe_b, bus_busy_b);
      else
        n_pass++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_a = 4'd0;
    req_b = 2'd0;
    tick();
    tick();
    mon_en = 1'b1;
    n_checks++;
    if ({oe_a, bus_busy_a, burst_cnt_a, grant_id_a} !== 16'h0000)
      $display("FAIL reset_a actual=%h required=0000", {oe_a, bus_busy_a, burst_cnt_a, grant_id_a});
    else
      n_pass++;
    n_checks++;
    if ({oe_b, bus_busy_b, burst_cnt_b, grant_id_b} !== 14'h0000)
      $display("FAIL reset_b actual=%h required=0000", {oe_b, bus_busy_b, burst_cnt_b, grant_id_b});
    else
      n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    req_a = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (oe_a !== 4'b0001 || bus_busy_a !== 1'b1 || burst_cnt_a !== 8'((i % 8) + 1))
        $display("FAIL single cyc=%0d actual oe=%b busy=%b burst=%0d required oe=0001 busy=1 burst=%0d",
                 i, oe_a, bus_busy_a, burst_cnt_a, (i % 8) + 1);
      else
        n_pass++;
      n_checks++;
      if (got_a() !== exp_vec(0))
        $display("FAIL single_model cyc=%0d actual=%h required=%h", i, got_a(), exp_vec(0));
      else
        n_pass++;
    end
  endtask

  task automatic test_release();
    logic [3:0] want;
    req_a = 4'd0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 6; i++) begin
      req_a = (i < 3) ? 4'b0100 : 4'b0000;
      tick();
      want = (i < 3) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (oe_a !== want)
        $display("FAIL release cyc=%0d actual oe=%b required oe=%b", i, oe_a, want);
      else
        n_pass++;
      n_checks++;
      if (got_a() !== exp_vec(0))
        $display("FAIL release_model cyc=%0d actual=%h required=%h", i, got_a(), exp_vec(0));
      else
        n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int run = 0;
    int zrun = 0;
    bit prev_busy = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (got_a() !== exp_vec(0))
        $display("FAIL rr_model cyc=%0d actual=%h required=%h", i, got_a(), exp_vec(0));
      else
        n_pass++;
      if (bus_busy_a) begin
        if (!prev_busy) begin
          order.push_back(int'(grant_id_a));
          if (order.size() > 1) begin
            n_checks++;
            if (zrun != 1) $display("FAIL rr_gap actual=%0d required=1", zrun);
            else n_pass++;
          end
          run = 0;
        end
        run++;
      end else begin
        if (prev_busy) begin
          n_checks++;
          if (run != 8) $display("FAIL rr_hold actual=%0d required=8", run);
          else n_pass++;
          zrun = 0;
        end
        zrun++;
      end
      prev_busy = bus_busy_a;
    end
    n_checks++;
    if (order.size() != 5) $display("FAIL rr_count actual=%0d required=5", order.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      n_checks++;
      if (order[k] != exp_order[k])
        $display("FAIL rr_order idx=%0d actual=%0d required=%0d", k, order[k], exp_order[k]);
      else
        n_pass++;
    end
  endtask

  task automatic test_forced_release();
    int guard = 0;
    req_a = 4'd0;
    tick();
    tick();
    req_a = 4'b0001;
    tick();
    while (!(m_owner[0] == 0 && m_held[0] == 5) && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 20 || burst_cnt_a !== 8'd5)
      $display("FAIL forced_setup actual burst=%0d required=5", burst_cnt_a);
    else
      n_pass++;
    req_a = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (got_a() !== exp_vec(0))
        $display("FAIL forced_model cyc=%0d actual=%h required=%h", i, got_a(), exp_vec(0));
      else
        n_pass++;
      if (i == 2) begin
        n_checks++;
        if (oe_a !== 4'b0001 || burst_cnt_a !== 8'd8)
          $display("FAIL forced_last actual oe=%b burst=%0d required oe=0001 burst=8", oe_a, burst_cnt_a);
        else
          n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (oe_a !== 4'b0000) $display("FAIL forced_turn actual oe=%b required 0000", oe_a);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (oe_a !== 4'b0100) $display("FAIL forced_next actual oe=%b required 0100", oe_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    req_a = 4'd0;
    tick();
    reset = 1'b0;
    req_a = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (oe_a !== 4'b0010) $display("FAIL rmid_grant actual oe=%b required 0010", oe_a);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({oe_a, bus_busy_a, burst_cnt_a, grant_id_a} !== 16'h0000)
      $display("FAIL rmid_grant_reset actual=%h required=0000", {oe_a, bus_busy_a, burst_cnt_a, grant_id_a});
    else
      n_pass++;
    reset = 1'b0;
    tick();
    req_a = 4'b0000;
    tick();
    n_checks++;
    if (oe_a !== 4'b0000) $display("FAIL rmid_turn actual oe=%b required 0000", oe_a);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a = 4'b0110;
    tick();
    n_checks++;
    if (oe_a !== 4'b0010 || grant_id_a !== 3'd1)
      $display("FAIL rmid_after actual oe=%b id=%0d required oe=0010 id=1", oe_a, grant_id_a);
    else
      n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (got_a() !== exp_vec(0))
        $display("FAIL rmid_model cyc=%0d actual=%h required=%h", i, got_a(), exp_vec(0));
      else
        n_pass++;
    end
  endtask

  task automatic test_turnaround();
    int order[$];
    int zrun = 0;
    bit prev_busy = 1'b0;
    reset = 1'b1;
    req_a = 4'd0;
    tick();
    reset = 1'b0;
    req_b = 2'b11;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_checks++;
      if (got_b() !== exp_vec(1))
        $display("FAIL ta_model cyc=%0d actual=%h required=%h", i, got_b(), exp_vec(1));
      else
        n_pass++;
      if (bus_busy_b && !prev_busy) begin
        order.push_back(int'(grant_id_b));
        if (order.size() > 1) begin
          n_checks++;
          if (zrun != 3) $display("FAIL ta_gap actual=%0d required=3", zrun);
          else n_pass++;
        end
      end
      if (!bus_busy_b) zrun = prev_busy ? 1 : zrun + 1;
      prev_busy = bus_busy_b;
    end
    n_checks++;
    if (order.size() < 6) $display("FAIL ta_count actual=%0d required>=6", order.size());
    else n_pass++;
    for (int k = 0; k < 6 && k < order.size(); k++) begin
      n_checks++;
      if (order[k] != k % 2)
        $display("FAIL ta_order idx=%0d actual=%0d required=%0d", k, order[k], k % 2);
      else
        n_pass++;
    end
    req_b = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) req_a = req_a ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) req_b = req_b ^ 2'(1 << $urandom_range(0, 1));
      reset = ($urandom_range(0, 149) == 0);
      tick();
      n_checks++;
      if (got_a() !== exp_vec(0))
        $display("FAIL rand_a cyc=%0d actual=%h required=%h", i, got_a(), exp_vec(0));
      else
        n_pass++;
      n_checks++;
      if (got_b() !== exp_vec(1))
        $display("FAIL rand_b cyc=%0d actual=%h required=%h", i, got_b(), exp_vec(1));
      else
        n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    #1;
    test_reset();
    test_single();
    test_release();
    test_round_robin();
    test_forced_release();
    test_reset_mid();
    test_turnaround();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
